// File: rtl/axis_rr_packet_arbiter_if.sv
// ============================================================================
//  Module   : axis_rr_packet_arbiter_if
//  Brief    : N-source upstream / single downstream AXI-stream bundle
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface axis_rr_packet_arbiter_if #(
    parameter int N_INPUTS = 4,
    parameter int DWIDTH   = 32
);
    localparam int c_SW = $clog2(N_INPUTS);

    logic [N_INPUTS*DWIDTH-1:0] s_data;
    logic [N_INPUTS-1:0]        s_valid;
    logic [N_INPUTS-1:0]        s_last;
    logic [N_INPUTS-1:0]        s_ready;
    logic [DWIDTH-1:0]          m_data;
    logic                       m_valid;
    logic                       m_last;
    logic                       m_ready;
    logic [c_SW-1:0]            m_src;
    logic                       busy;

    // Arbiter side: consumes the upstream streams, drives the downstream one.
    modport slave (
        input  s_data, s_valid, s_last, m_ready,
        output s_ready, m_data, m_valid, m_last, m_src, busy
    );

    // Environment side: sources and sink around the arbiter.
    modport master (
        output s_data, s_valid, s_last, m_ready,
        input  s_ready, m_data, m_valid, m_last, m_src, busy
    );
endinterface

`default_nettype wire

// File: rtl/axis_rr_packet_arbiter.sv
// ============================================================================
//  Module   : axis_rr_packet_arbiter
//  Brief    : packet-granular round-robin mux of N AXI-streams onto one
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module axis_rr_packet_arbiter #(
    parameter int N_INPUTS = 4,
    parameter int DWIDTH   = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    axis_rr_packet_arbiter_if.slave  bus
);
    localparam int       c_SW     = $clog2(N_INPUTS);
    localparam bit [0:0] c_IDLE   = 1'b0;
    localparam bit [0:0] c_LOCKED = 1'b1;

    logic [0:0]      r_state;
    logic [0:0]      w_state_next;
    logic [c_SW-1:0] r_grant;
    logic [c_SW-1:0] r_prio;
    logic [c_SW-1:0] w_pick;
    logic            w_found;
    int              w_idx;

    // Scan downward so the nearest requester after r_prio is the final winner.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = 0;
        for (int k = N_INPUTS; k >= 1; k--) begin
            w_idx = (int'(r_prio) + k) % N_INPUTS;
            if (bus.s_valid[w_idx]) begin
                w_found = 1'b1;
                w_pick  = c_SW'(w_idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_grant <= '0;
            r_prio  <= c_SW'(N_INPUTS - 1);
        end else begin
            r_state <= w_state_next;
            if (r_state == c_IDLE && w_found) begin
                r_grant <= w_pick;
                r_prio  <= w_pick;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_found) w_state_next = c_LOCKED;
            end
            c_LOCKED: begin
                if (bus.s_valid[r_grant] && bus.m_ready && bus.s_last[r_grant])
                    w_state_next = c_IDLE;
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    // Zero-latency pass-through of the granted source; everything quiet in IDLE.
    always_comb begin
        bus.s_ready = '0;
        bus.m_data  = '0;
        bus.m_valid = 1'b0;
        bus.m_last  = 1'b0;
        bus.m_src   = '0;
        bus.busy    = 1'b0;
        if (r_state == c_LOCKED) begin
            bus.m_data           = bus.s_data[int'(r_grant)*DWIDTH +: DWIDTH];
            bus.m_valid          = bus.s_valid[r_grant];
            bus.m_last           = bus.s_last[r_grant];
            bus.m_src            = r_grant;
            bus.busy             = 1'b1;
            bus.s_ready[r_grant] = bus.m_ready;
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_axis_rr_packet_arbiter.sv
// ============================================================================
//  Module   : tb_axis_rr_packet_arbiter
//  Brief    : randomized scoreboard bench for axis_rr_packet_arbiter
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_axis_rr_packet_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;

    typedef struct {
        int          dly;
        logic        last;
        logic [31:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    axis_rr_packet_arbiter_if #(.N_INPUTS(N), .DWIDTH(DW)) bus ();

    axis_rr_packet_arbiter #(.N_INPUTS(N), .DWIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    beat_t       stim_q [N][$];
    logic [32:0] exp_q  [N][$];
    int          glog   [$];
    bit          rand_arr [N];
    bit          rand_ready;
    int          rst_cycles;
    bit          mdl_locked;
    int          total;
    int          bad;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout expected completion at %0t", name, $time);
    endtask

    task automatic add_beat(input int src, input logic [31:0] data, input logic last, input int dly);
        beat_t b;
        b.dly  = dly;
        b.last = last;
        b.data = data;
        stim_q[src].push_back(b);
        exp_q[src].push_back({last, data});
    endtask

    task automatic add_pkt(input int src, input int len, input logic [31:0] base, input int dly);
        for (int k = 0; k < len; k++)
            add_beat(src, base + 32'(k), (k == len - 1), (k == 0) ? dly : 0);
    endtask

    // Sources and sink: beats advance on observed handshakes, optional random gaps.
    initial begin : driver
        bit    acc [N];
        beat_t b;
        bit    v;
        reset       = 1'b1;
        bus.s_data  = '0;
        bus.s_valid = '0;
        bus.s_last  = '0;
        bus.m_ready = 1'b0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) acc[i] = bus.s_valid[i] & bus.s_ready[i];
            @(posedge clk);
            #1;
            if (rst_cycles > 0) begin
                rst_cycles--;
                reset       = 1'b1;
                bus.s_valid = '0;
                bus.s_last  = '0;
                for (int i = 0; i < N; i++) begin
                    stim_q[i].delete();
                    exp_q[i].delete();
                end
            end else begin
                reset = 1'b0;
                for (int i = 0; i < N; i++) begin
                    if (acc[i] && stim_q[i].size() > 0) void'(stim_q[i].pop_front());
                    v = 1'b0;
                    if (stim_q[i].size() > 0) begin
                        b = stim_q[i][0];
                        if (b.dly > 0) begin
                            b.dly--;
                            stim_q[i][0] = b;
                        end else begin
                            v = (!rand_arr[i] || (bus.s_valid[i] && !acc[i])) ? 1'b1 : 1'($urandom % 2);
                            bus.s_data[i*DW +: DW] = b.data;
                            bus.s_last[i]          = b.last;
                        end
                    end
                    bus.s_valid[i] = v;
                end
            end
            bus.m_ready = rand_ready ? 1'($urandom % 2) : 1'b1;
        end
    end

    // Reference: packet-locked round robin from the last granted index.
    initial begin : monitor
        int          g;
        int          prio;
        int          idx;
        bit          first;
        logic [32:0] e;
        logic [N-1:0] exp_rdy;
        g          = 0;
        prio       = N - 1;
        first      = 1'b0;
        mdl_locked = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                mdl_locked = 1'b0;
                g          = 0;
                prio       = N - 1;
                continue;
            end
            exp_rdy = mdl_locked ? (N'(bus.m_ready) << g) : '0;
            check("busy",    64'(bus.busy),    64'(mdl_locked));
            check("m_valid", 64'(bus.m_valid), 64'(mdl_locked & bus.s_valid[g]));
            check("s_ready", 64'(bus.s_ready), 64'(exp_rdy));
            if (mdl_locked) begin
                check("m_src", 64'(bus.m_src), 64'(g));
                if (first) begin
                    glog.push_back(int'(bus.m_src));
                    first = 1'b0;
                end
                if (bus.s_valid[g] && bus.m_ready) begin
                    if (exp_q[g].size() == 0) begin
                        check("extra_beat", 64'(bus.m_data), 64'hdead);
                    end else begin
                        e = exp_q[g].pop_front();
                        check("m_data", 64'(bus.m_data), 64'(e[31:0]));
                        check("m_last", 64'(bus.m_last), 64'(e[32]));
                    end
                    if (bus.s_last[g]) mdl_locked = 1'b0;
                end
            end else begin
                check("idle_m_data", 64'(bus.m_data), 64'h0);
                check("idle_m_last", 64'(bus.m_last), 64'h0);
                check("idle_m_src",  64'(bus.m_src),  64'h0);
                if (|bus.s_valid) begin
                    for (int k = 1; k <= N; k++) begin
                        idx = (prio + k) % N;
                        if (bus.s_valid[idx]) begin
                            g = idx;
                            break;
                        end
                    end
                    prio       = g;
                    mdl_locked = 1'b1;
                    first      = 1'b1;
                end
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #3;
    endtask

    task automatic do_reset();
        rst_cycles = 2;
        for (int t = 0; t < 20 && (rst_cycles > 0 || reset); t++) sync();
        sync();
        glog.delete();
    endtask

    task automatic wait_drain(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int t = 0; t < budget && !done; t++) begin
            sync();
            done = 1'b1;
            for (int i = 0; i < N; i++)
                if (stim_q[i].size() != 0 || exp_q[i].size() != 0) done = 1'b0;
            if (mdl_locked) done = 1'b0;
        end
        if (!done) fail(name);
        sync();
        sync();
    endtask

    task automatic check_glog(input string name, input int exp []);
        check({name, "_count"}, 64'(glog.size()), 64'(exp.size()));
        for (int k = 0; k < exp.size() && k < glog.size(); k++)
            check(name, 64'(glog[k]), 64'(exp[k]));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish expected finish by %0t", $time);
        $fatal(1);
    end

    initial begin : main
        int exp_rr [];
        int n_sent;
        int len;
        bit hit;
        total      = 0;
        bad        = 0;
        rand_ready = 1'b0;
        rst_cycles = 0;
        for (int i = 0; i < N; i++) rand_arr[i] = 1'b0;
        do_reset();

        // Single source, 5 beats.
        add_pkt(2, 5, 32'hA0, 0);
        wait_drain("single_drain", 50);
        check_glog("single_grant", '{2});

        // All sources continuously requesting: 3 packets each.
        do_reset();
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < N; i++)
                add_pkt(i, 3, 32'(i << 4) + 32'(p << 8), 0);
        wait_drain("rr_drain", 200);
        exp_rr = new[12];
        for (int k = 0; k < 12; k++) exp_rr[k] = k % N;
        check_glog("rr_order", exp_rr);

        // Source 1, 100 words with random gaps and random backpressure.
        do_reset();
        rand_arr[1] = 1'b1;
        rand_ready  = 1'b1;
        n_sent      = 0;
        while (n_sent < 100) begin
            len = int'($urandom_range(1, 8));
            if (n_sent + len > 100) len = 100 - n_sent;
            add_pkt(1, len, 32'h1000_0000 + 32'(n_sent), int'($urandom_range(0, 2)));
            n_sent += len;
        end
        wait_drain("bp_drain", 3000);
        rand_arr[1] = 1'b0;
        rand_ready  = 1'b0;

        // Lock hold across a valid gap while source 3 waits.
        do_reset();
        add_beat(0, 32'h01, 1'b0, 0);
        add_beat(0, 32'h02, 1'b0, 0);
        add_beat(0, 32'h03, 1'b1, 10);
        add_pkt(3, 2, 32'h30, 2);
        wait_drain("hold_drain", 100);
        check_glog("hold_grant", '{0, 3});

        // Reset in the middle of an 8-beat packet from source 1.
        do_reset();
        add_pkt(1, 8, 32'h100, 0);
        hit = 1'b0;
        for (int t = 0; t < 50 && !hit; t++) begin
            sync();
            if (exp_q[1].size() <= 6) hit = 1'b1;
        end
        if (!hit) fail("midrst_progress");
        do_reset();
        add_pkt(0, 2, 32'h200, 0);
        add_pkt(1, 2, 32'h210, 0);
        wait_drain("midrst_drain", 100);
        check_glog("midrst_grant", '{0, 1});

        // Source 1 first asserts valid on the cycle source 2's last completes.
        do_reset();
        add_pkt(2, 3, 32'h2A0, 0);
        add_pkt(1, 2, 32'h1A0, 3);
        wait_drain("simul_drain", 100);
        check_glog("simul_grant", '{2, 1});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/axis_rr_packet_arbiter.md
Name: axis_rr_packet_arbiter

Overview:
Shares one downstream AXI-stream (Axis_If-style data/valid/ready/last) between N upstream AXI-stream sources. Arbitration is round-robin at packet granularity: once a source is granted, it owns the output until its beat with last set is accepted. Used wherever several capture/readout producers feed one DMA or readout stream. It also reports which source owns the current beat.

Parameters:
N_INPUTS, 4, number of upstream sources; legal range 2..16.
DWIDTH, 32, data width per stream.

Ports:
clk  input  1  system clock.
reset  input  1  synchronous, active-high reset.
s_data  input  N_INPUTS*DWIDTH  upstream data; source i occupies bits [i*DWIDTH +: DWIDTH].
s_valid  input  N_INPUTS  upstream valid, one bit per source.
s_last  input  N_INPUTS  upstream last, one bit per source.
s_ready  output  N_INPUTS  upstream ready, one bit per source.
m_data  output  DWIDTH  downstream data.
m_valid  output  1  downstream valid.
m_last  output  1  downstream last.
m_ready  input  1  downstream ready.
m_src  output  $clog2(N_INPUTS)  index of the source driving m_data; valid only while m_valid=1.
busy  output  1  high while in LOCKED.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- State and registers:
  - state in {IDLE, LOCKED}.
  - grant: $clog2(N_INPUTS)-bit register.
  - prio_ptr: index of the last granted source.
- Reset values:
  - state=IDLE, grant=0, prio_ptr=N_INPUTS-1, so source 0 has first priority.
  - All outputs are combinational from registers and inputs. While in IDLE: s_ready=0, m_valid=0, m_last=0, m_data=0, m_src=0, busy=0.
- IDLE:
  - If any s_valid bit is set, choose the first set bit scanning (prio_ptr+1), (prio_ptr+2), ... modulo N_INPUTS.
  - Register grant=chosen, prio_ptr=chosen, go to LOCKED.
  - No transfer occurs in the IDLE cycle. Arbitration latency is 1 cycle from first valid to first m_valid.
- LOCKED:
  - m_data=s_data[grant], m_valid=s_valid[grant], m_last=s_last[grant], m_src=grant, busy=1.
  - s_ready[grant]=m_ready; all other s_ready bits are 0.
  - Path is a zero-latency pass-through with no buffering. ok = m_valid & m_ready.
  - On ok with m_last=1: return to IDLE at the next edge. This gives exactly one bubble cycle between packets.
  - Otherwise stay in LOCKED, including when the granted s_valid drops mid-packet: the grant is held and other sources keep waiting.
- Fairness:
  - With all N sources continuously requesting, grant order is 0,1,...,N-1,0,...
  - No source waits more than N-1 packets.
- Simultaneous events:
  - A source asserting valid in the same cycle another's last beat completes is considered in the following IDLE cycle, from the updated prio_ptr.
  - The granted source may win again only if no other source requests.
- Single-beat packets (valid and last together): one beat, then IDLE.
- Reset mid-packet: state goes to IDLE at that edge and m_valid/s_ready fall to 0 immediately after. The partial packet is truncated; cleanup is the caller's responsibility. prio_ptr returns to N_INPUTS-1.
- Downstream backpressure (m_ready=0): the granted s_ready is 0; data, last and m_src stay stable as driven by the source.
- Protocol: the block never asserts more than one s_ready bit, and never asserts m_valid in IDLE.

Test Plan:
- Single source: after reset, source 2 sends a 5-beat packet (0xA0..0xA4, last on 0xA4) with m_ready=1. Required: m_valid rises 1 cycle after s_valid[2]; m_src=2; 5 beats out in order; m_last only on 0xA4; IDLE the next cycle.
- Round-robin: all 4 sources hold 3-beat packets tagged 0x{i}0..0x{i}2, continuously refilled, for 12 packets. Required: m_src sequence 0,1,2,3,0,1,2,3,...; no interleaving within a packet; exactly one idle cycle between packets.
- Backpressure and gaps: source 1 sends 100 beats with random valid (send_samples rand_arrivals=1); downstream uses do_readout rand_ready=1. Required: all 100 words appear in order, no duplicates or drops, and s_ready[0,2,3] stays 0 throughout.
- Lock hold: source 0 sends 2 beats without last, then drops valid for 10 cycles while source 3 is valid. Required: m_src stays 0 and m_valid=0 during the gap; source 3 is granted only after source 0's last beat.
- Reset mid-packet: assert reset during beat 3 of 8 from source 1. Required: m_valid=0 and s_ready=0 in the cycle after the reset edge. With sources 0 and 1 requesting after reset, source 0 is granted first.
- Simultaneous last and new request: source 2's last completes in the same cycle source 1 first asserts valid, with prio_ptr=2 and source 0 idle. Required: the next grant is source 1 after one IDLE cycle.
